// File: rtl/y_row_line_buffer.sv
// y_row_line_buffer: captures two Y-memory lines for a row and streams the selected 16-bit entries over valid/ready.
module y_row_line_buffer (
  input  logic         clock,
  input  logic         reset,
  input  logic         lb_enable,
  input  logic         lb_start,
  input  logic [3:0]   lb_offset,
  input  logic [5:0]   lb_count,
  input  logic [255:0] lb_memData,
  input  logic         lb_outReady,
  output logic [15:0]  lb_outData,
  output logic         lb_outValid,
  output logic         lb_busy,
  output logic         lb_done,
  output logic         lb_overrun
);
  typedef enum logic [2:0] {IDLE, CAP1, CAP2, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [511:0] buffer;
  logic [4:0] index;
  logic [5:0] remaining, room, eff_count;
  logic xfer;
  // clamping the count to the entries left in the buffer keeps index within 0..31
  assign room = 6'd32 - {2'b00, lb_offset};
  assign eff_count = lb_count < room ? lb_count : room;
  assign lb_outValid = lb_enable && state == EMIT;
  assign lb_done = lb_enable && state == DONE;
  assign lb_busy = state != IDLE;
  assign xfer = lb_outValid && lb_outReady;
  assign lb_outData = buffer[{index, 4'b0000} +: 16];
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = lb_start ? CAP1 : IDLE;
      CAP1: state_n = CAP2;
      CAP2: state_n = remaining == 6'd0 ? DONE : EMIT;
      EMIT: state_n = (xfer && remaining == 6'd1) ? DONE : EMIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      buffer <= '0;
      index <= '0;
      remaining <= '0;
      lb_overrun <= 1'b0;
    end else if (lb_enable) begin
      state <= state_n;
      if (state == IDLE && lb_start) begin
        index <= {1'b0, lb_offset};
        remaining <= eff_count;
      end
      if (state == CAP1) buffer[255:0] <= lb_memData;
      if (state == CAP2) buffer[511:256] <= lb_memData;
      if (xfer) begin
        index <= index + 5'd1;
        remaining <= remaining - 6'd1;
      end
      if (lb_start && state != IDLE) lb_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_y_row_line_buffer.sv
// tb_y_row_line_buffer: randomized runs checked against a queue-based model of the row stream.
module tb_y_row_line_buffer;
  logic clock = 1'b0, reset = 1'b0, lb_enable = 1'b0, lb_start = 1'b0, lb_outReady = 1'b0;
  logic [3:0] lb_offset = '0;
  logic [5:0] lb_count = '0;
  logic [255:0] lb_memData = '0;
  logic [15:0] lb_outData;
  logic lb_outValid, lb_busy, lb_done, lb_overrun;
  int total = 0, bad = 0;
  int rdy_pct, stall_pct, ov_cyc, st_lo, st_hi, rst_after, done_cyc;
  bit rpat_en, ov_exp = 1'b0;
  bit [5:0] rpat;
  logic [15:0] ent [32];

  always #5 clock = ~clock;

  y_row_line_buffer dut (
    .clock(clock), .reset(reset), .lb_enable(lb_enable), .lb_start(lb_start),
    .lb_offset(lb_offset), .lb_count(lb_count), .lb_memData(lb_memData),
    .lb_outReady(lb_outReady), .lb_outData(lb_outData), .lb_outValid(lb_outValid),
    .lb_busy(lb_busy), .lb_done(lb_done), .lb_overrun(lb_overrun)
  );

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task defaults();
    rdy_pct = 100; stall_pct = 0; ov_cyc = -1; st_lo = 1000; st_hi = -1;
    rst_after = -1; rpat_en = 1'b0; rpat = '0;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task check_idle_zero(input string tag);
    chk({tag, "_data"}, 32'(lb_outData), 0);
    chk({tag, "_valid"}, 32'(lb_outValid), 0);
    chk({tag, "_busy"}, 32'(lb_busy), 0);
    chk({tag, "_done"}, 32'(lb_done), 0);
    chk({tag, "_ovr"}, 32'(lb_overrun), 0);
  endtask

  // one row transaction: entries offset..offset+eff-1 are expected in order,
  // the phase advances only on enabled cycles (upstream stalls with us)
  task automatic run(input int off, input int cnt, input bit seq_data);
    logic [255:0] l1, l2;
    logic [15:0] q [$];
    int eff, ph, cyc, ecyc, xfers;
    bit fin, en, emit, donep;
    for (int k = 0; k < 32; k++)
      ent[k] = seq_data ? 16'(k < 16 ? 'h1000 + k : 'h2000 + k - 16) : 16'($urandom);
    for (int k = 0; k < 16; k++) begin
      l1[16*k +: 16] = ent[k];
      l2[16*k +: 16] = ent[k+16];
    end
    eff = cnt < 32 - off ? cnt : 32 - off;
    q.delete();
    for (int i = 0; i < eff; i++) q.push_back(ent[off+i]);
    ph = 0; cyc = 0; ecyc = 0; xfers = 0; fin = 1'b0; done_cyc = -1;
    while (!fin && cyc < 400) begin
      en = (cyc == 0) || (!(cyc >= st_lo && cyc <= st_hi) && $urandom_range(0, 99) >= stall_pct);
      emit = ph >= 3 && q.size() > 0;
      donep = ph >= 3 && q.size() == 0;
      reset = !(rst_after >= 0 && xfers == rst_after && emit);
      lb_enable = en;
      lb_start = (cyc == 0) || (cyc == ov_cyc);
      lb_offset = cyc == 0 ? 4'(off) : 4'($urandom);
      lb_count = cyc == 0 ? 6'(cnt) : 6'($urandom_range(0, 32));
      lb_memData = ph == 1 ? l1 : ph == 2 ? l2 : rnd256();
      lb_outReady = (emit && rpat_en && ecyc < 6) ? rpat[ecyc] : ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (!reset) begin
        @(posedge clock); #1;
        reset = 1'b1; lb_enable = 1'b1; lb_start = 1'b0; ov_exp = 1'b0;
        #1;
        check_idle_zero("midrst");
        @(posedge clock); #1;
        return;
      end
      chk("busy", 32'(lb_busy), 32'(ph >= 1));
      chk("valid", 32'(lb_outValid), 32'(en && emit));
      chk("done", 32'(lb_done), 32'(en && donep));
      chk("overrun", 32'(lb_overrun), 32'(ov_exp));
      if (emit) chk("data", 32'(lb_outData), 32'(q[0]));
      if (en) begin
        if (lb_start && ph >= 1) ov_exp = 1'b1;
        if (emit) begin
          ecyc++;
          if (lb_outReady) begin
            void'(q.pop_front());
            xfers++;
          end
        end
        if (donep) begin
          fin = 1'b1;
          done_cyc = cyc;
        end
        ph++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    defaults();
    reset = 1'b0; lb_enable = 1'b1; lb_start = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check_idle_zero("reset");
    reset = 1'b1; lb_start = 1'b0;
    @(posedge clock); #1;
    run(0, 32, 1'b1);
    chk("basic_done_cyc", done_cyc, 35);
    run(13, 32, 1'b1);
    chk("clamp_done_cyc", done_cyc, 22);
    rpat_en = 1'b1; rpat = 6'b110010;
    run(2, 3, 1'b1);
    chk("bp_done_cyc", done_cyc, 9);
    defaults();
    run(0, 0, 1'b1);
    chk("zero_done_cyc", done_cyc, 3);
    ov_cyc = 2; st_lo = 5; st_hi = 7;
    run(0, 8, 1'b1);
    chk("stall_done_cyc", done_cyc, 14);
    chk("ovr_sticky", 32'(lb_overrun), 1);
    defaults();
    rst_after = 4;
    run(0, 32, 1'b1);
    defaults();
    run(5, 10, 1'b0);
    chk("after_rst_done_cyc", done_cyc, 13);
    for (int n = 0; n < 40; n++) begin
      rdy_pct = $urandom_range(30, 100);
      stall_pct = $urandom_range(0, 30);
      ov_cyc = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 20)) : -1;
      rst_after = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 3)) : -1;
      run($urandom_range(0, 15), $urandom_range(0, 32), 1'b0);
      defaults();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
